// File: rtl/stack_cmd_pkg.sv
// Shared encodings for the LIFO stack command front-end.
// Holds the command opcodes seen on cmd_op and the controller FSM states.
package stack_cmd_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/stack_cmd_ctrl.sv
// Command front-end for the 8x8 LIFO stack.
// Accepts PUSH/POP/PEEK/NOP commands, issues one strobe to the stack per
// legal command, tracks occupancy and returns one response per command.
// Optional build macro STACK_CMD_CTRL_STATS_EN adds a saturating 16-bit
// illegal-command counter on output err_cnt.
// Note: rst does not reach the stack itself, so a reset in the middle of an
// operation leaves the stack pointer stale; reset must coincide with stack
// initialisation at power-up.
module stack_cmd_ctrl
    import stack_cmd_pkg::*;
#(
    parameter  int DATA_WIDTH  = 8,
    parameter  int STACK_DEPTH = 8,
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_peak,
    output logic [DATA_WIDTH-1:0] stk_data_in,
    input  logic [DATA_WIDTH-1:0] stk_data_out,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
`ifdef STACK_CMD_CTRL_STATS_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    state_e                r_state;
    state_e                w_next;
    cmd_op_e               r_op;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_err;
    logic [CNT_W-1:0]      r_count;
    logic                  w_has_room;
    logic                  w_not_empty;
    logic                  w_legal;

    assign w_has_room  = (r_count < CNT_W'(STACK_DEPTH));
    assign w_not_empty = (r_count != '0);

    // Legality is judged only against the registered occupancy.
    always_comb begin
        w_legal = 1'b0;
        case (r_op)
            OP_PUSH: w_legal = w_has_room;
            OP_POP:  w_legal = w_not_empty;
            OP_PEEK: w_legal = w_not_empty;
            default: w_legal = 1'b0;
        endcase
    end

    assign cmd_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_err;
    assign count      = r_count;
    assign full       = (r_count == CNT_W'(STACK_DEPTH));
    assign empty      = (r_count == '0);

    // FSM state register; reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and stack strobes; strobes are decoded from state so they
    // vanish the moment reset is applied.
    always_comb begin
        w_next      = r_state;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_peak    = 1'b0;
        stk_data_in = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_next = (cmd_op == OP_NOP) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_legal) begin
                    case (r_op)
                        OP_PUSH: begin
                            stk_push    = 1'b1;
                            stk_data_in = r_data;
                        end
                        OP_POP:  stk_pop  = 1'b1;
                        OP_PEEK: stk_peak = 1'b1;
                        default: ;
                    endcase
                end
                w_next = ST_CAPTURE;
            end
            ST_CAPTURE: w_next = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command capture, occupancy tracking and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= OP_NOP;
            r_data      <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op_e'(cmd_op);
                        r_data      <= cmd_data;
                        r_err       <= 1'b0;
                        r_resp_data <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_err <= ~w_legal;
                    if (w_legal && r_op == OP_PUSH) begin
                        r_count <= r_count + CNT_W'(1);
                    end else if (w_legal && r_op == OP_POP) begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (!r_err && (r_op == OP_POP || r_op == OP_PEEK)) begin
                        r_resp_data <= stk_data_out;
                    end else begin
                        r_resp_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STACK_CMD_CTRL_STATS_EN
    logic [15:0] r_err_cnt;

    // Saturating count of commands rejected in ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (r_state == ST_ISSUE && !w_legal && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
// Self-checking bench for stack_cmd_ctrl.
// A queue-based stack model predicts each response at command acceptance;
// a negedge monitor compares strobes and responses against it, and the main
// sequence adds hand-computed literal expectations.
module tb_stack_cmd_ctrl;
    import stack_cmd_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         count;
        int         strobe;
        logic [7:0] pushData;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_peak;
    logic [DW-1:0] stk_data_in;
    logic [DW-1:0] stk_data_out = '0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
`ifdef STACK_CMD_CTRL_STATS_EN
    logic [15:0]   err_cnt;
`endif

    exp_t       expQ[$];
    logic [7:0] mdl[$];
    int         mdlErrCnt = 0;
    int         tests = 0;
    int         failed = 0;
    int         strobesSeen = 0;
    int         obsKind;
    exp_t       curExp;
    logic [7:0] rd;
    logic       re;

    logic [7:0] stkMem [8];
    logic [3:0] stkPtr = 4'd0;
    logic [3:0] stkTop;

    stack_cmd_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_peak     (stk_peak),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .count        (count),
        .full         (full),
        .empty        (empty)
`ifdef STACK_CMD_CTRL_STATS_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Behavioural 8-entry LIFO; dataOut is valid the cycle after a pop/peek.
    assign stkTop = stkPtr - 4'd1;
    always @(posedge clk) begin
        if (stk_push) begin
            stkMem[stkPtr[2:0]] <= stk_data_in;
            stkPtr <= stkPtr + 4'd1;
        end else if (stk_pop) begin
            stk_data_out <= stkMem[stkTop[2:0]];
            stkPtr <= stkTop;
        end else if (stk_peak) begin
            stk_data_out <= stkMem[stkTop[2:0]];
        end
    end

    // Monitor: checks every strobe and every response handshake against the model.
    always @(negedge clk) begin
        if (rst) begin
            strobesSeen = 0;
        end else begin
            if (stk_push || stk_pop || stk_peak) begin
                obsKind = stk_push ? 1 : (stk_pop ? 2 : 3);
                checkOutput("strobe_onehot", 32'($countones({stk_push, stk_pop, stk_peak})), 32'd1);
                if (expQ.size() == 0) begin
                    checkOutput("strobe_without_cmd", 32'(expQ.size()), 32'd1);
                end else begin
                    checkOutput("strobe_kind", 32'(obsKind), 32'(expQ[0].strobe));
                    if (stk_push) checkOutput("stk_data_in", 32'(stk_data_in), 32'(expQ[0].pushData));
                end
                strobesSeen++;
            end
            if (resp_valid && resp_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("resp_without_cmd", 32'(expQ.size()), 32'd1);
                end else begin
                    curExp = expQ.pop_front();
                    checkOutput("resp_data", 32'(resp_data), 32'(curExp.data));
                    checkOutput("resp_err", 32'(resp_err), 32'(curExp.err));
                    checkOutput("count", 32'(count), 32'(curExp.count));
                    checkOutput("full", 32'(full), 32'(curExp.count == DEPTH));
                    checkOutput("empty", 32'(empty), 32'(curExp.count == 0));
                    checkOutput("strobe_pulses", 32'(strobesSeen), 32'(curExp.strobe != 0));
                    checkOutput("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
`ifdef STACK_CMD_CTRL_STATS_EN
                    checkOutput("err_cnt", 32'(err_cnt), 32'(mdlErrCnt));
`endif
                end
                strobesSeen = 0;
            end
        end
    end

    // Issues one command, records the model expectation, returns the response.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] d, input int holdLow,
                                 output logic [7:0] rdOut, output logic reOut);
        int   n;
        exp_t e;
        @(posedge clk); #2;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = d;
        resp_ready = (holdLow == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        e.data = 8'h00; e.err = 1'b0; e.strobe = 0; e.pushData = 8'h00;
        case (op)
            OP_PUSH: if (mdl.size() < DEPTH) begin
                         mdl.push_back(d); e.strobe = 1; e.pushData = d;
                     end else e.err = 1'b1;
            OP_POP:  if (mdl.size() > 0) begin
                         e.data = mdl.pop_back(); e.strobe = 2;
                     end else e.err = 1'b1;
            OP_PEEK: if (mdl.size() > 0) begin
                         e.data = mdl[$]; e.strobe = 3;
                     end else e.err = 1'b1;
            default: ;
        endcase
        if (e.err && mdlErrCnt < 65535) mdlErrCnt++;
        e.count = mdl.size();
        expQ.push_back(e);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        n = 0;
        while (!resp_valid && n < 10) begin
            @(posedge clk); #2;
            n++;
        end
        if (!resp_valid) checkOutput("resp_valid_timeout", 32'(resp_valid), 32'd1);
        rdOut = resp_data;
        reOut = resp_err;
        for (int i = 0; i < holdLow; i++) begin
            @(posedge clk); #2;
            checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_resp_data", 32'(resp_data), 32'(rdOut));
            checkOutput("hold_resp_err", 32'(resp_err), 32'(reOut));
            checkOutput("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_data   = 8'h00;
        resp_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_strobes", 32'({stk_push, stk_pop, stk_peak}), 32'd0);
        checkOutput("rst_stk_data_in", 32'(stk_data_in), 32'd0);
`ifdef STACK_CMD_CTRL_STATS_EN
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

        applyStimulus(OP_PUSH, 8'hA5, 0, rd, re);
        checkOutput("push_a5_err", 32'(re), 32'd0);
        checkOutput("push_a5_count", 32'(count), 32'd1);
        applyStimulus(OP_POP, 8'h00, 0, rd, re);
        checkOutput("pop_a5_data", 32'(rd), 32'hA5);
        checkOutput("pop_a5_count", 32'(count), 32'd0);

        applyStimulus(OP_PUSH, 8'h11, 0, rd, re);
        applyStimulus(OP_PUSH, 8'h22, 0, rd, re);
        applyStimulus(OP_PUSH, 8'h33, 0, rd, re);
        applyStimulus(OP_PEEK, 8'h00, 0, rd, re);
        checkOutput("peek_33", 32'(rd), 32'h33);
        applyStimulus(OP_POP, 8'h00, 0, rd, re);
        checkOutput("pop_33", 32'(rd), 32'h33);
        applyStimulus(OP_POP, 8'h00, 0, rd, re);
        checkOutput("pop_22", 32'(rd), 32'h22);
        applyStimulus(OP_POP, 8'h00, 0, rd, re);
        checkOutput("pop_11", 32'(rd), 32'h11);
        checkOutput("empty_after_pops", 32'(empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) applyStimulus(OP_PUSH, 8'(8'h40 + i), 0, rd, re);
        checkOutput("full_after_8", 32'(full), 32'd1);
        checkOutput("count_after_8", 32'(count), 32'd8);
        applyStimulus(OP_PUSH, 8'hFF, 0, rd, re);
        checkOutput("push_full_err", 32'(re), 32'd1);
        checkOutput("push_full_count", 32'(count), 32'd8);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(OP_POP, 8'h00, 0, rd, re);
            checkOutput("pop_drain", 32'(rd), 32'(8'h47 - i));
        end
        applyStimulus(OP_POP, 8'h00, 0, rd, re);
        checkOutput("pop_empty_err", 32'(re), 32'd1);
        checkOutput("pop_empty_data", 32'(rd), 32'd0);
        applyStimulus(OP_PEEK, 8'h00, 0, rd, re);
        checkOutput("peek_empty_err", 32'(re), 32'd1);
`ifdef STACK_CMD_CTRL_STATS_EN
        checkOutput("err_cnt_three", 32'(err_cnt), 32'd3);
`endif

        applyStimulus(OP_PUSH, 8'h5A, 0, rd, re);
        applyStimulus(OP_POP, 8'h00, 5, rd, re);
        checkOutput("pop_held_5a", 32'(rd), 32'h5A);

        // Reset asserted in the middle of the ISSUE cycle of a PUSH.
        @(posedge clk); #2;
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 8'h77;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        checkOutput("issue_push_strobe", 32'(stk_push), 32'd1);
        checkOutput("issue_push_data", 32'(stk_data_in), 32'h77);
        #1 rst = 1'b1;
        mdl.delete();
        mdlErrCnt = 0;
        #1;
        checkOutput("midrst_strobe", 32'({stk_push, stk_pop, stk_peak}), 32'd0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        applyStimulus(OP_NOP, 8'h99, 0, rd, re);
        checkOutput("nop_err", 32'(re), 32'd0);
        checkOutput("nop_data", 32'(rd), 32'd0);

        repeat (3) @(posedge clk);
        checkOutput("expq_drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
